// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller. Resolves load-use bubbles,
//                data-memory wait freezes and taken-branch flushes with a
//                fixed priority, watches for memory requests that never
//                complete (timeout -> absorbing FAULT) and counts stalled
//                cycles in a saturating 16-bit performance counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    // Consecutive MEM_WAIT cycles tolerated before fault; legal range 2..31
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  ID_rs1_i,
    input  logic [4:0]  ID_rs2_i,
    input  logic        EX_MemRead_i,
    input  logic [4:0]  EX_rd_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    input  logic        branch_taken_i,
    output logic        PC_write_o,
    output logic        IF_ID_write_o,
    output logic        IF_ID_flush_o,
    output logic        ctrl_flush_o,
    output logic        stall_o,
    output logic        fault_o,
    output logic [15:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    // Last wait_cnt value at which an un-acked request is still tolerated
    localparam logic [4:0]  c_WAIT_LAST = 5'(MEM_TIMEOUT - 1);
    localparam logic [15:0] c_CNT_MAX   = 16'hFFFF;

    state_t      r_state;
    logic [4:0]  r_wait_cnt;
    logic [15:0] r_stall_cycles;

    logic        w_load_use;
    logic        w_mem_busy;

    // Hazard detection on the current ID/EX/MEM contents
    always_comb begin
        w_load_use = EX_MemRead_i && (EX_rd_i != 5'd0) &&
                     ((EX_rd_i == ID_rs1_i) || (EX_rd_i == ID_rs2_i));
        w_mem_busy = mem_req_i && !mem_ack_i;
    end

    // Pipeline control outputs, priority FAULT > mem_busy > load_use > branch
    always_comb begin
        PC_write_o    = 1'b1;
        IF_ID_write_o = 1'b1;
        IF_ID_flush_o = 1'b0;
        ctrl_flush_o  = 1'b0;
        stall_o       = 1'b0;
        fault_o       = 1'b0;
        if (r_state == ST_FAULT) begin
            PC_write_o    = 1'b0;
            IF_ID_write_o = 1'b0;
            stall_o       = 1'b1;
            fault_o       = 1'b1;
        end else if (w_mem_busy) begin
            // Whole pipeline frozen while the data memory is outstanding
            PC_write_o    = 1'b0;
            IF_ID_write_o = 1'b0;
            stall_o       = 1'b1;
        end else if (w_load_use) begin
            // Hold PC and IF/ID, inject one bubble into ID/EX
            PC_write_o    = 1'b0;
            IF_ID_write_o = 1'b0;
            ctrl_flush_o  = 1'b1;
        end else if (branch_taken_i) begin
            IF_ID_flush_o = 1'b1;
        end
    end

    // Memory-wait state machine with timeout watchdog
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 5'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_wait_cnt <= 5'd0;
                    if (w_mem_busy) begin
                        r_state <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    // An ack or a withdrawn request both end the wait
                    if (!w_mem_busy) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= 5'd0;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state <= ST_FAULT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 5'd1;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= 5'd0;
                end
            endcase
        end
    end

    // Saturating count of cycles lost to stalls and bubbles
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cycles <= 16'd0;
        end else if ((stall_o || ctrl_flush_o) && (r_stall_cycles != c_CNT_MAX)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles_o = r_stall_cycles;

endmodule
`default_nettype wire
